// File: rtl/dm_pkg.sv
// dm_pkg: shared definitions for the data-memory arbiter.
//   CTRL_*  : DMCtrl size/sign encodings understood by DataMemory.
//   state_t : arbiter FSM states (IDLE -> ACCESS -> RESP -> IDLE).
package dm_pkg;

   localparam logic [2:0] CTRL_B  = 3'b000;
   localparam logic [2:0] CTRL_H  = 3'b001;
   localparam logic [2:0] CTRL_W  = 3'b010;
   localparam logic [2:0] CTRL_BU = 3'b100;
   localparam logic [2:0] CTRL_HU = 3'b101;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

endpackage

// File: rtl/dm_align_check.sv
// dm_align_check: combinational legality check for one memory access.
//   Addr[1:0] : low address bits of the access
//   Ctrl      : size/sign code (B, H, W, BU, HU)
//   Wr        : 1 = store, 0 = load
//   Err       : 1 when the access must be rejected (misaligned H/HU/W,
//               reserved Ctrl code, or unsigned-load code used as a store)
module dm_align_check
   import dm_pkg::*;
(
   input  logic [1:0] Addr,
   input  logic [2:0] Ctrl,
   input  logic       Wr,
   output logic       Err
);

   always_comb begin
      Err = 1'b1;
      case (Ctrl)
         CTRL_B:  Err = 1'b0;
         CTRL_H:  Err = Addr[0];
         CTRL_W:  Err = |Addr;
         CTRL_BU: Err = Wr;
         CTRL_HU: Err = Wr | Addr[0];
         default: Err = 1'b1;
      endcase
   end

endmodule

// File: rtl/dm_arbiter.sv
// dm_arbiter: two-requester round-robin arbiter in front of DataMemory.
//   clk, rst                 : clock, synchronous active-high reset
//   Req/Addr/WrData/Wr/Ctrl  : requester 0 (core) and 1 (DMA/debug) inputs
//   Ack/RdData/Err           : one-cycle response to the served requester
//   Address/DataWr/DMWr/DMCtrl : DataMemory drive, active only in ACCESS
//   DataRd                   : combinational DataMemory read data
// Each access takes IDLE -> ACCESS -> RESP, one access per three cycles.
module dm_arbiter
   import dm_pkg::*;
#(
   parameter int AW = 32,
   parameter int DW = 32
)
(
   input  logic          clk,
   input  logic          rst,
   input  logic          Req0,
   input  logic          Req1,
   input  logic [AW-1:0] Addr0,
   input  logic [AW-1:0] Addr1,
   input  logic [DW-1:0] WrData0,
   input  logic [DW-1:0] WrData1,
   input  logic          Wr0,
   input  logic          Wr1,
   input  logic [2:0]    Ctrl0,
   input  logic [2:0]    Ctrl1,
   output logic          Ack0,
   output logic          Ack1,
   output logic [DW-1:0] RdData0,
   output logic [DW-1:0] RdData1,
   output logic          Err0,
   output logic          Err1,
   output logic [AW-1:0] Address,
   output logic [DW-1:0] DataWr,
   output logic          DMWr,
   output logic [2:0]    DMCtrl,
   input  logic [DW-1:0] DataRd
);

   state_t        r_state;
   logic          r_ptr;     // requester that wins when both request
   logic          r_win;     // requester being served
   logic [AW-1:0] r_addr;
   logic [DW-1:0] r_wdata;
   logic          r_wr;
   logic [2:0]    r_ctrl;
   logic [DW-1:0] r_rdata;
   logic          r_err;

   logic          w_pick1;
   logic          w_err;
   logic          w_access;
   logic          w_resp;

   // A lone request wins outright; a tie goes to the pointer.
   assign w_pick1 = Req1 & (~Req0 | r_ptr);

   dm_align_check u_align_check (
      .Addr (r_addr[1:0]),
      .Ctrl (r_ctrl),
      .Wr   (r_wr),
      .Err  (w_err)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= IDLE;
         r_ptr   <= 1'b0;
         r_win   <= 1'b0;
         r_addr  <= '0;
         r_wdata <= '0;
         r_wr    <= 1'b0;
         r_ctrl  <= CTRL_W;
         r_rdata <= '0;
         r_err   <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (Req0 | Req1) begin
                  r_win   <= w_pick1;
                  r_addr  <= w_pick1 ? Addr1   : Addr0;
                  r_wdata <= w_pick1 ? WrData1 : WrData0;
                  r_wr    <= w_pick1 ? Wr1     : Wr0;
                  r_ctrl  <= w_pick1 ? Ctrl1   : Ctrl0;
                  r_state <= ACCESS;
               end
            end
            ACCESS: begin
               // Stores and rejected accesses return zero data.
               r_rdata <= (r_wr | w_err) ? '0 : DataRd;
               r_err   <= w_err;
               r_state <= RESP;
            end
            RESP: begin
               r_ptr   <= ~r_win;
               r_state <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   // Gating with rst keeps outputs idle in the reset cycle itself, so a
   // reset landing in ACCESS never produces a partial store.
   assign w_access = (r_state == ACCESS) & ~rst;
   assign w_resp   = (r_state == RESP) & ~rst;

   assign Address = w_access ? r_addr  : '0;
   assign DataWr  = w_access ? r_wdata : '0;
   assign DMCtrl  = w_access ? r_ctrl  : CTRL_W;
   assign DMWr    = w_access & r_wr & ~w_err;

   assign Ack0    = w_resp & ~r_win;
   assign Ack1    = w_resp & r_win;
   assign RdData0 = Ack0 ? r_rdata : '0;
   assign RdData1 = Ack1 ? r_rdata : '0;
   assign Err0    = Ack0 & r_err;
   assign Err1    = Ack1 & r_err;

endmodule

// File: tb/tb_dm_arbiter.sv
module tb_dm_arbiter;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        Req0 = 1'b0, Req1 = 1'b0;
   logic [31:0] Addr0 = '0, Addr1 = '0, WrData0 = '0, WrData1 = '0;
   logic        Wr0 = 1'b0, Wr1 = 1'b0;
   logic [2:0]  Ctrl0 = 3'b010, Ctrl1 = 3'b010;
   logic        Ack0, Ack1, Err0, Err1, DMWr;
   logic [31:0] RdData0, RdData1, Address, DataWr, DataRd;
   logic [2:0]  DMCtrl;

   always #5 clk = ~clk;

   dm_arbiter #(.AW(32), .DW(32)) dut (
      .clk(clk), .rst(rst),
      .Req0(Req0), .Req1(Req1), .Addr0(Addr0), .Addr1(Addr1),
      .WrData0(WrData0), .WrData1(WrData1), .Wr0(Wr0), .Wr1(Wr1),
      .Ctrl0(Ctrl0), .Ctrl1(Ctrl1), .Ack0(Ack0), .Ack1(Ack1),
      .RdData0(RdData0), .RdData1(RdData1), .Err0(Err0), .Err1(Err1),
      .Address(Address), .DataWr(DataWr), .DMWr(DMWr), .DMCtrl(DMCtrl),
      .DataRd(DataRd)
   );

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        wr;
      logic [2:0]  ctrl;
   } txn_t;

   typedef struct {
      int          who;
      logic [31:0] rdata;
      logic        err;
      int          cyc;
   } log_t;

   txn_t q0[$], q1[$];
   log_t mlog[$];

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int dmwr_cnt = 0;
   bit ack_seen0 = 0, ack_seen1 = 0;

   // Environment DataMemory (16 words), written on observed DMWr.
   logic [31:0] mem [0:15];
   logic [31:0] rd_word, rd_sh;
   always_comb begin
      rd_word = mem[Address[5:2]];
      rd_sh   = rd_word >> {Address[1:0], 3'b000};
      case (DMCtrl)
         3'b000:  DataRd = {{24{rd_sh[7]}}, rd_sh[7:0]};
         3'b001:  DataRd = {{16{rd_sh[15]}}, rd_sh[15:0]};
         3'b010:  DataRd = rd_word;
         3'b100:  DataRd = {24'b0, rd_sh[7:0]};
         3'b101:  DataRd = {16'b0, rd_sh[15:0]};
         default: DataRd = '0;
      endcase
   end

   // ---------------- reference model (transaction level) ----------------
   logic [7:0]  rm [0:63];     // byte-addressed little-endian memory
   bit          busy = 0, pref = 0, win = 0;
   int          g = 0;         // cycle number of the grant edge
   txn_t        cur;
   logic        cur_err;
   bit          exp_ack0 = 0, exp_ack1 = 0, exp_acc = 0;
   logic [31:0] exp_rdata = '0;
   logic        exp_err = 1'b0;

   function automatic int size_of(logic [2:0] c);
      case (c[1:0])
         2'b00:   return 1;
         2'b01:   return 2;
         2'b10:   return 4;
         default: return 0;
      endcase
   endfunction

   function automatic logic is_err(txn_t t);
      int n;
      n = size_of(t.ctrl);
      if (n == 0 || t.ctrl == 3'b110) return 1'b1;
      if (t.ctrl[2] && t.wr) return 1'b1;
      if ((int'(t.addr[5:0]) % n) != 0) return 1'b1;
      return 1'b0;
   endfunction

   task automatic model_commit();
      int n, a;
      logic [31:0] v;
      n = size_of(cur.ctrl);
      a = int'(cur.addr[5:0]);
      v = '0;
      if (!cur_err) begin
         if (cur.wr) begin
            for (int k = 0; k < n; k++) rm[a+k] = cur.wdata[8*k +: 8];
         end else begin
            for (int k = 0; k < n; k++) v[8*k +: 8] = rm[a+k];
            if (!cur.ctrl[2] && n == 1) v = {{24{v[7]}}, v[7:0]};
            if (!cur.ctrl[2] && n == 2) v = {{16{v[15]}}, v[15:0]};
         end
      end
      exp_rdata = v;
      exp_err   = cur_err;
      mlog.push_back('{int'(win), v, cur_err, cyc});
   endtask

   task automatic model_step();
      cyc++;
      exp_ack0 = 0;
      exp_ack1 = 0;
      if (rst) begin
         busy = 0;
         pref = 0;
      end else if (!busy) begin
         if (Req0 || Req1) begin
            win = (Req0 && Req1) ? pref : Req1;
            if (win) cur = '{Addr1, WrData1, Wr1, Ctrl1};
            else     cur = '{Addr0, WrData0, Wr0, Ctrl0};
            cur_err = is_err(cur);
            busy = 1;
            g = cyc;
         end
      end else if (cyc == g + 1) begin
         model_commit();
         if (win) exp_ack1 = 1;
         else     exp_ack0 = 1;
      end else begin
         busy = 0;
         pref = !win;
      end
      exp_acc = busy && (cyc == g);
   endtask

   initial begin
      for (int i = 0; i < 64; i++) begin
         logic [31:0] w;
         w = 32'hC0DE0000 + 32'(i / 4);
         rm[i] = w[8*(i%4) +: 8];
      end
      forever begin
         @(posedge clk);
         model_step();
      end
   end

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: actual=%h expected=%h", nm, cyc, act, exp);
      end
   endtask

   // ---------------- per-cycle compare ----------------
   initial begin
      for (int i = 0; i < 16; i++) mem[i] = 32'hC0DE0000 + 32'(i);
      forever begin
         @(negedge clk);
         if (rst) begin
            chk("rst Ack0", Ack0, 0);       chk("rst Ack1", Ack1, 0);
            chk("rst RdData0", RdData0, 0); chk("rst RdData1", RdData1, 0);
            chk("rst Err0", Err0, 0);       chk("rst Err1", Err1, 0);
            chk("rst Address", Address, 0); chk("rst DataWr", DataWr, 0);
            chk("rst DMWr", DMWr, 0);       chk("rst DMCtrl", DMCtrl, 3'b010);
         end else begin
            chk("Ack0", Ack0, exp_ack0);
            chk("Ack1", Ack1, exp_ack1);
            if (exp_ack0) begin
               chk("RdData0", RdData0, exp_rdata);
               chk("Err0", Err0, exp_err);
               ack_seen0 = 1;
            end
            if (exp_ack1) begin
               chk("RdData1", RdData1, exp_rdata);
               chk("Err1", Err1, exp_err);
               ack_seen1 = 1;
            end
            if (exp_acc) begin
               chk("Address", Address, cur.addr);
               chk("DataWr", DataWr, cur.wdata);
               chk("DMCtrl", DMCtrl, cur.ctrl);
               chk("DMWr", DMWr, cur.wr && !cur_err);
            end else begin
               chk("idle Address", Address, 0);
               chk("idle DataWr", DataWr, 0);
               chk("idle DMCtrl", DMCtrl, 3'b010);
               chk("idle DMWr", DMWr, 0);
            end
         end
         if (DMWr === 1'b1) begin
            dmwr_cnt++;
            case (DMCtrl[1:0])
               2'b00:   mem[Address[5:2]][8*Address[1:0] +: 8]  = DataWr[7:0];
               2'b01:   mem[Address[5:2]][8*Address[1:0] +: 16] = DataWr[15:0];
               default: mem[Address[5:2]] = DataWr;
            endcase
         end
      end
   end

   // ---------------- stimulus ----------------
   task automatic step();
      @(posedge clk);
      #1;
      if (ack_seen0) begin ack_seen0 = 0; if (q0.size() > 0) void'(q0.pop_front()); end
      if (ack_seen1) begin ack_seen1 = 0; if (q1.size() > 0) void'(q1.pop_front()); end
      // Once granted, the owner scrambles its fields: the arbiter must use its latch.
      if (busy && win == 0) begin
         Req0 = 1; Addr0 = $urandom; WrData0 = $urandom; Wr0 = 1'($urandom_range(0, 1));
         Ctrl0 = 3'($urandom_range(0, 7));
      end else if (q0.size() > 0) begin
         Req0 = 1; Addr0 = q0[0].addr; WrData0 = q0[0].wdata; Wr0 = q0[0].wr; Ctrl0 = q0[0].ctrl;
      end else Req0 = 0;
      if (busy && win == 1) begin
         Req1 = 1; Addr1 = $urandom; WrData1 = $urandom; Wr1 = 1'($urandom_range(0, 1));
         Ctrl1 = 3'($urandom_range(0, 7));
      end else if (q1.size() > 0) begin
         Req1 = 1; Addr1 = q1[0].addr; WrData1 = q1[0].wdata; Wr1 = q1[0].wr; Ctrl1 = q1[0].ctrl;
      end else Req1 = 0;
   endtask

   task automatic drain(string nm);
      int n;
      n = 0;
      while ((q0.size() > 0 || q1.size() > 0 || busy) && n < 200) begin
         step();
         n++;
      end
      chk(nm, (n < 200) ? 1 : 0, 1);
   endtask

   task automatic flush();
      q0.delete(); q1.delete();
      ack_seen0 = 0; ack_seen1 = 0;
   endtask

   function automatic txn_t rand_txn();
      txn_t t;
      logic [2:0] codes [13];
      codes = '{3'b000, 3'b001, 3'b010, 3'b100, 3'b101, 3'b000, 3'b001,
                3'b010, 3'b100, 3'b101, 3'b011, 3'b110, 3'b111};
      t.ctrl  = codes[$urandom_range(0, 12)];
      t.addr  = 32'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 1) t.addr[1:0] = 2'b00;
      t.wr    = 1'($urandom_range(0, 1));
      t.wdata = $urandom;
      return t;
   endfunction

   int mark, d0, s;
   bit found;

   initial begin
      repeat (3) step();
      rst = 0;

      // store word then load it back
      mark = mlog.size(); d0 = dmwr_cnt;
      q0.push_back('{32'h0, 32'hAABBCCDD, 1'b1, 3'b010});
      q0.push_back('{32'h0, 32'h0, 1'b0, 3'b010});
      drain("drain sw/lw");
      chk("sw/lw count", mlog.size() - mark, 2);
      chk("sw rdata", mlog[mark].rdata, 0);
      chk("lw rdata", mlog[mark+1].rdata, 32'hAABBCCDD);
      chk("lw err", mlog[mark+1].err, 0);
      chk("sw DMWr cycles", dmwr_cnt - d0, 1);

      // byte store, signed and unsigned byte loads by requester 1
      mark = mlog.size();
      q1.push_back('{32'h4, 32'hEE, 1'b1, 3'b000});
      q1.push_back('{32'h4, 32'h0, 1'b0, 3'b000});
      q1.push_back('{32'h4, 32'h0, 1'b0, 3'b100});
      drain("drain sb/lb");
      chk("lb who", mlog[mark+1].who, 1);
      chk("lb rdata", mlog[mark+1].rdata, 32'hFFFFFFEE);
      chk("lbu rdata", mlog[mark+2].rdata, 32'h000000EE);

      // simultaneous requests straight out of reset
      rst = 1; step(); step(); rst = 0;
      mark = mlog.size();
      q0.push_back('{32'h0, 32'h0, 1'b0, 3'b010});
      q1.push_back('{32'h4, 32'h0, 1'b0, 3'b010});
      drain("drain tie");
      chk("tie first", mlog[mark].who, 0);
      chk("tie second", mlog[mark+1].who, 1);
      chk("tie spacing", mlog[mark+1].cyc - mlog[mark].cyc, 3);
      chk("tie rd0", mlog[mark].rdata, 32'hAABBCCDD);
      chk("tie rd1", mlog[mark+1].rdata, 32'hC0DE00EE);

      // misaligned stores are rejected and leave memory alone
      mark = mlog.size(); d0 = dmwr_cnt;
      q0.push_back('{32'h9, 32'hBEEF, 1'b1, 3'b001});
      q0.push_back('{32'h6, 32'hDEADBEEF, 1'b1, 3'b010});
      q0.push_back('{32'h8, 32'h0, 1'b0, 3'b010});
      q0.push_back('{32'h4, 32'h0, 1'b0, 3'b010});
      drain("drain misalign");
      chk("sh err", mlog[mark].err, 1);
      chk("sw err", mlog[mark+1].err, 1);
      chk("err rdata", mlog[mark+1].rdata, 0);
      chk("mem 0x8", mlog[mark+2].rdata, 32'hC0DE0002);
      chk("mem 0x4", mlog[mark+3].rdata, 32'hC0DE00EE);
      chk("misalign DMWr cycles", dmwr_cnt - d0, 0);

      // reset during ACCESS aborts the store
      mark = mlog.size(); d0 = dmwr_cnt; found = 0;
      q1.push_back('{32'hC, 32'h12345678, 1'b1, 3'b010});
      for (int i = 0; i < 20 && !found; i++) begin
         step();
         if (busy && win == 1 && cyc == g) found = 1;
      end
      chk("abort reached ACCESS", found, 1);
      rst = 1;
      flush();
      step();
      rst = 0;
      chk("abort no Ack", mlog.size() - mark, 0);
      chk("abort DMWr cycles", dmwr_cnt - d0, 0);
      mark = mlog.size();
      q1.push_back('{32'hC, 32'h0, 1'b0, 3'b010});
      drain("drain abort");
      chk("abort mem 0xC", mlog[mark].rdata, 32'hC0DE0003);

      // reserved Ctrl code, fixed latency
      mark = mlog.size();
      q0.push_back('{32'h10, 32'h0, 1'b0, 3'b111});
      step();
      s = cyc;
      drain("drain ctrl111");
      chk("ctrl111 err", mlog[mark].err, 1);
      chk("ctrl111 rdata", mlog[mark].rdata, 0);
      chk("ctrl111 latency", mlog[mark].cyc - s, 2);

      // randomized traffic with occasional resets
      for (int i = 0; i < 800; i++) begin
         step();
         if (q0.size() == 0 && $urandom_range(0, 2) == 0) q0.push_back(rand_txn());
         if (q1.size() == 0 && $urandom_range(0, 2) == 0) q1.push_back(rand_txn());
         if ($urandom_range(0, 99) == 0) begin
            rst = 1;
            flush();
            step();
            rst = 0;
         end
      end
      drain("drain random");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout: simulation did not complete");
      $fatal(1, "timeout");
   end

endmodule
